// File: rtl/bus_decoder.sv
// Memory-bus decoder: base/mask windows per slave, one-hot read mux, stall timeout
// with a one-cycle abort, and fault address/count capture.
//
// state   | meaning
// IDLE    | no stalled transaction; zero-wait hits complete here
// WAIT    | selected slave has not yet raised ready; stall_cnt counts stall cycles
// ABORT   | one-cycle timeout response (ready_out=fault_out=1, no slave selected)
module bus_decoder #(
    parameter int                          NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE     = {32'h10000000, 32'h01000000, 32'h00030000,
                                                            32'h00020000, 32'h00010000},
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK     = {32'hFFFF0000, 32'hFF000000, 32'hFFFFFFF0,
                                                            32'hFFFFFFF0, 32'hFFFFFFFC},
    parameter int                          TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  address_in,
    input  logic                         read_in,
    input  logic [3:0]                   write_mask_in,
    input  logic [31:0]                  write_value_in,
    output logic [31:0]                  read_value_out,
    output logic                         ready_out,
    output logic                         fault_out,
    output logic [NUM_SLAVES-1:0]        sel_out,
    input  logic [NUM_SLAVES*32-1:0]     slave_read_value_in,
    input  logic [NUM_SLAVES-1:0]        slave_ready_in,
    output logic [31:0]                  fault_address_out,
    output logic [7:0]                   fault_count_out
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       stall_cnt;
    logic [31:0]         latched_addr;

    logic                req;
    logic [NUM_SLAVES-1:0] hit;
    logic                hit_any;
    logic                sel_ready;

    // Write data goes to the slaves outside this block.
    logic                unused_wdata;
    assign unused_wdata = ^write_value_in;

    assign req = read_in | (|write_mask_in);

    // Scan from the top index down so the lowest matching window is the one left set.
    always_comb begin
        hit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((address_in & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    assign hit_any   = |hit;
    assign sel_out   = (req && state != ST_ABORT) ? hit : '0;
    assign sel_ready = |(sel_out & slave_ready_in);

    always_comb begin
        read_value_out = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_out[i]) begin
                read_value_out = slave_read_value_in[32*i +: 32];
            end
        end
    end

    always_comb begin
        ready_out = 1'b0;
        fault_out = 1'b0;
        if (req && !hit_any) begin
            ready_out = 1'b1;
            fault_out = 1'b1;
        end else if (state == ST_ABORT) begin
            ready_out = 1'b1;
            fault_out = 1'b1;
        end else begin
            ready_out = sel_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            stall_cnt    <= '0;
            latched_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && hit_any && !sel_ready) begin
                        state        <= ST_WAIT;
                        stall_cnt    <= CW'(1);
                        latched_addr <= address_in;
                    end
                end
                ST_WAIT: begin
                    if (sel_ready || !req) begin
                        state     <= ST_IDLE;
                        stall_cnt <= '0;
                    end else if (address_in != latched_addr) begin
                        stall_cnt    <= CW'(1);
                        latched_addr <= address_in;
                    end else if (TIMEOUT_CYCLES != 0 && stall_cnt == CW'(TIMEOUT_CYCLES)) begin
                        state     <= ST_ABORT;
                        stall_cnt <= '0;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + CW'(1);
                    end
                end
                ST_ABORT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_address_out <= '0;
            fault_count_out   <= '0;
        end else if (fault_out) begin
            fault_address_out <= address_in;
            if (fault_count_out != 8'hFF) begin
                fault_count_out <= fault_count_out + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized scoreboard bench for bus_decoder: the driver predicts each transaction's
// completion cycle, data, select and fault; a negedge monitor checks every ready_out.
module tb_bus_decoder;

    localparam int NS = 5;
    localparam int TO = 16;
    localparam logic [NS*32-1:0] BASE_P = {32'h10000000, 32'h01000000, 32'h00030000,
                                           32'h00020000, 32'h00010000};
    localparam logic [NS*32-1:0] MASK_P = {32'hFFFF0000, 32'hFF000000, 32'hFFFFFFF0,
                                           32'hFFFFFFF0, 32'hFFFFFFFC};

    logic [31:0] win_base [NS] = '{32'h00010000, 32'h00020000, 32'h00030000,
                                   32'h01000000, 32'h10000000};
    logic [31:0] win_mask [NS] = '{32'hFFFFFFFC, 32'hFFFFFFF0, 32'hFFFFFFF0,
                                   32'hFF000000, 32'hFFFF0000};

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     address_in;
    logic            read_in;
    logic [3:0]      write_mask_in;
    logic [31:0]     write_value_in;
    logic [31:0]     read_value_out;
    logic            ready_out;
    logic            fault_out;
    logic [NS-1:0]   sel_out;
    logic [NS*32-1:0] slave_read_value_in;
    logic [NS-1:0]   slave_ready_in;
    logic [31:0]     fault_address_out;
    logic [7:0]      fault_count_out;

    bus_decoder #(
        .NUM_SLAVES(NS), .SLAVE_BASE(BASE_P), .SLAVE_MASK(MASK_P), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .address_in(address_in), .read_in(read_in),
        .write_mask_in(write_mask_in), .write_value_in(write_value_in),
        .read_value_out(read_value_out), .ready_out(ready_out), .fault_out(fault_out),
        .sel_out(sel_out), .slave_read_value_in(slave_read_value_in),
        .slave_ready_in(slave_ready_in), .fault_address_out(fault_address_out),
        .fault_count_out(fault_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fault;
        logic [31:0]   data;
        logic [NS-1:0] sel;
        int            done_cyc;
        logic [31:0]   addr;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          model_cnt = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & win_mask[i]) == win_base[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // noise=1: every other slave shows all-ones data and ready=1 throughout.
    task automatic run_txn(input logic [31:0] addr, input logic rd, input logic [3:0] wm,
                           input int lat, input logic [31:0] tdata, input bit noise);
        int   idx;
        int   off;
        exp_t e;
        idx = decode(addr);
        e.addr = addr;
        if (idx < 0) begin
            off = 0; e.fault = 1'b1; e.data = '0; e.sel = '0;
        end else if (lat <= TO) begin
            off = lat; e.fault = 1'b0; e.data = tdata; e.sel = '0; e.sel[idx] = 1'b1;
        end else begin
            off = TO + 1; e.fault = 1'b1; e.data = '0; e.sel = '0;
        end
        e.done_cyc = cyc + off;
        q.push_back(e);
        address_in = addr; read_in = rd; write_mask_in = wm; write_value_in = $urandom;
        for (int i = 0; i < NS; i++)
            slave_read_value_in[32*i +: 32] = noise ? 32'hFFFFFFFF : 32'($urandom);
        if (idx >= 0) slave_read_value_in[32*idx +: 32] = tdata;
        for (int k = 0; k <= off; k++) begin
            slave_ready_in = noise ? '1 : NS'($urandom);
            if (idx >= 0) slave_ready_in[idx] = (k == lat);
            step();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            read_in = 1'b0; write_mask_in = '0; address_in = $urandom;
            slave_ready_in = NS'($urandom);
            step();
        end
    endtask

    // Monitor: fault-register follow-up first, then any response in this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("fault_address", fault_address_out, pend_addr);
                check("fault_count", fault_count_out, model_cnt);
                pend = 0;
            end
            if (q.size() > 0 && cyc > q[0].done_cyc) begin
                check("missing_ready", 1'b0, 1'b1);
                void'(q.pop_front());
            end
            if (ready_out) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", ready_out, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("ready_cycle", cyc, e.done_cyc);
                    check("fault_out", fault_out, e.fault);
                    check("read_value", read_value_out, e.data);
                    check("sel_out", sel_out, e.sel);
                    if (e.fault) begin
                        if (model_cnt < 255) model_cnt++;
                        pend = 1;
                        pend_addr = e.addr;
                    end
                end
            end
        end
    end

    initial begin
        int          s;
        logic [31:0] a;
        logic        rd;
        reset = 1'b0;
        address_in = '0; read_in = 1'b0; write_mask_in = '0; write_value_in = '0;
        slave_read_value_in = '0; slave_ready_in = '0;
        #12;
        check("rst_sel", sel_out, '0);
        check("rst_ready", ready_out, 1'b0);
        check("rst_fault", fault_out, 1'b0);
        check("rst_rdata", read_value_out, '0);
        check("rst_faddr", fault_address_out, '0);
        check("rst_fcnt", fault_count_out, '0);
        step();
        reset = 1'b1;
        idle(2);

        run_txn(32'h10000040, 1'b1, 4'b0000, 1, 32'hDEADBEEF, 1'b0);
        idle(1);
        run_txn(32'h00010000, 1'b0, 4'b0001, 0, 32'h000000A5, 1'b1);
        idle(1);
        run_txn(32'h20000000, 1'b1, 4'b0000, 0, 32'h0, 1'b0);
        idle(1);
        run_txn(32'h00020004, 1'b1, 4'b0000, 1000, 32'h0, 1'b0);
        run_txn(32'h00020004, 1'b1, 4'b0000, 3, 32'h12345678, 1'b0);
        idle(1);
        run_txn(32'h00030008, 1'b1, 4'b0000, TO, 32'hCAFEF00D, 1'b0);
        idle(1);
        run_txn(32'h01ABCDE0, 1'b0, 4'b1100, TO + 1, 32'h0, 1'b0);
        idle(2);

        for (int n = 0; n < 150; n++) begin
            s = $urandom_range(0, NS);
            if (s == NS) a = 32'h20000000 | (32'($urandom) & 32'h0FFFFFFF);
            else a = (win_base[s] & win_mask[s]) | (32'($urandom) & ~win_mask[s]);
            rd = 1'($urandom);
            run_txn(a, rd, rd ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15)),
                    $urandom_range(0, TO + 4), $urandom, 1'b0);
            idle($urandom_range(0, 1));
        end
        idle(2);

        for (int n = 0; n < 300; n++)
            run_txn(32'h20000000 + 32'(n * 4), 1'b1, 4'b0000, 0, 32'h0, 1'b0);
        idle(2);
        check("fcnt_saturated", fault_count_out, 8'hFF);

        address_in = 32'h00020004; read_in = 1'b1; write_mask_in = '0;
        slave_ready_in = '0;
        for (int k = 0; k < 8; k++) step();
        #2;
        model_cnt = 0;
        pend = 0;
        reset = 1'b0;
        #1;
        check("midrst_fcnt", fault_count_out, 8'h00);
        check("midrst_faddr", fault_address_out, 32'h0);
        check("midrst_fault", fault_out, 1'b0);
        check("midrst_ready", ready_out, 1'b0);
        read_in = 1'b0;
        step();
        step();
        reset = 1'b1;
        idle(25);
        check("post_rst_fcnt", fault_count_out, 8'h00);
        run_txn(32'h10000100, 1'b1, 4'b0000, 2, 32'h0BADF00D, 1'b0);
        idle(3);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
